// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// phases, drives datapath selects and enables, and traps into a sticky ERROR state.
module mc_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Error,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    ERROR  = 4'd12
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  stateT         state;
  stateT         nextState;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] nextWaitCnt;
  logic          pcWrite;
  logic          branch;
  logic          memWait;
  logic          timedOut;

  // State and wait counter registers; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  assign memWait  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timedOut = (waitCnt == TIMEOUT_CNT) && !MemReady;

  // Counter only runs while stalling in a memory state, so it is zero on every entry.
  always_comb begin
    nextWaitCnt = '0;
    if (memWait && !MemReady && (nextState == state)) begin
      nextWaitCnt = waitCnt + CW'(1);
    end
  end

  // Next-state and output decode; anything not set for a state stays 0.
  always_comb begin
    nextState  = state;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    Error      = 1'b0;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    PCEn       = 1'b0;

    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        if (MemReady) begin
          IRWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end else if (timedOut) begin
          nextState = ERROR;
        end
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Opcode)
          OP_RTYPE:     nextState = EXEC;
          OP_LW, OP_SW: nextState = MEMADR;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JUMP;
          default:      nextState = ERROR;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        if (Opcode == OP_LW)      nextState = MEMRD;
        else if (Opcode == OP_SW) nextState = MEMWR;
        else                      nextState = ERROR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)      nextState = MEMWB;
        else if (timedOut) nextState = ERROR;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)      nextState = FETCH;
        else if (timedOut) nextState = ERROR;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        nextState = ALUWB;
        case (Funct)
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default: begin
            ALUControl = ALU_ADD;
            nextState  = ERROR;
          end
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        nextState  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        nextState  = ADDIWB;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        pcWrite   = 1'b1;
        nextState = FETCH;
      end
      ERROR: begin
        Error     = 1'b1;
        nextState = ERROR;
      end
      default: nextState = ERROR;
    endcase

    PCEn = pcWrite | (branch & Zero);

    // Nothing architectural may change during the reset cycle.
    if (rst) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: instruction-level scripts push the
// expected per-cycle control word, and a monitor compares it against the DUT each cycle.
module tb_mc_control_fsm;

  localparam int TO = 15;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXEC   = 6;
  localparam int P_ALUWB  = 7;
  localparam int P_BRANCH = 8;
  localparam int P_ADDIEX = 9;
  localparam int P_ADDIWB = 10;
  localparam int P_JUMP   = 11;
  localparam int P_ERROR  = 12;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  logic       CLK = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, PCEn, ALUSrcA;
  logic       RegWrite, RegDst, MemtoReg, Error;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic [5:0]  curOpc;
  logic [5:0]  curFn;
  logic [20:0] sbQ[$];
  int          total = 0;
  int          bad = 0;
  int          cycleNo = 0;
  logic [5:0]  legalFn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  mc_control_fsm #(.TIMEOUT(TO), .CW(8)) dut (
    .CLK(CLK), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .Error(Error), .State(State)
  );

  always #5 CLK = ~CLK;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit functLegal(input logic [5:0] fn);
    foreach (legalFn[i]) if (legalFn[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] aluFor(input logic [5:0] fn);
    if (fn == 6'h22) return 3'b110;
    if (fn == 6'h24) return 3'b000;
    if (fn == 6'h25) return 3'b001;
    if (fn == 6'h2A) return 3'b111;
    return 3'b010;
  endfunction

  // Control word the datapath should see for one phase, straight from the per-phase table.
  function automatic logic [20:0] expOut(input int ph, input logic [5:0] fn,
                                         input logic z, input logic mr, input logic r);
    logic err = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, pcen = 0, asa = 0;
    logic rw = 0, rd = 0, m2r = 0;
    logic [1:0] pcs = 0, asb = 0;
    logic [2:0] alu = 0;
    case (ph)
      P_FETCH:  begin mrd = 1; asb = 2'b01; alu = 3'b010; irw = mr; pcen = mr; end
      P_DECODE: begin asb = 2'b11; alu = 3'b010; end
      P_MEMADR: begin asa = 1; asb = 2'b10; alu = 3'b010; end
      P_MEMRD:  begin mrd = 1; iord = 1; end
      P_MEMWB:  begin m2r = 1; rw = 1; end
      P_MEMWR:  begin mwr = 1; iord = 1; end
      P_EXEC:   begin asa = 1; alu = aluFor(fn); end
      P_ALUWB:  begin rd = 1; rw = 1; end
      P_BRANCH: begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      P_ADDIEX: begin asa = 1; asb = 2'b10; alu = 3'b010; end
      P_ADDIWB: begin rw = 1; end
      P_JUMP:   begin pcs = 2'b10; pcen = 1; end
      P_ERROR:  begin err = 1; end
      default:  ;
    endcase
    if (r) begin mwr = 0; irw = 0; pcen = 0; rw = 0; end
    return {4'(ph), err, iord, mrd, mwr, irw, pcen, pcs, asa, asb, alu, rw, rd, m2r};
  endfunction

  // One clock of stimulus; the expected control word for this cycle goes to the scoreboard.
  task automatic applyStimulus(input int ph, input logic z, input logic mr, input logic r);
    Opcode = curOpc; Funct = curFn; Zero = z; MemReady = mr; rst = r;
    sbQ.push_back(expOut(ph, curFn, z, mr, r));
    @(posedge CLK); #1;
  endtask

  task automatic waitPhase(input int ph, input int waits, output bit ok);
    for (int i = 0; i < waits && i < TO + 1; i++) applyStimulus(ph, rb(), 1'b0, 1'b0);
    ok = (waits <= TO);
    if (ok) applyStimulus(ph, rb(), 1'b1, 1'b0);
  endtask

  task automatic errorTail(input int n);
    for (int i = 0; i < n; i++) applyStimulus(P_ERROR, rb(), rb(), 1'b0);
    applyStimulus(P_ERROR, rb(), rb(), 1'b1);
  endtask

  task automatic runInstr(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                          input int fw, input int mw);
    bit ok;
    curOpc = opc; curFn = fn;
    waitPhase(P_FETCH, fw, ok);
    if (!ok) begin errorTail(3); return; end
    applyStimulus(P_DECODE, rb(), rb(), 1'b0);
    case (opc)
      OP_R: begin
        applyStimulus(P_EXEC, rb(), rb(), 1'b0);
        if (functLegal(fn)) applyStimulus(P_ALUWB, rb(), rb(), 1'b0);
        else errorTail(4);
      end
      OP_LW: begin
        applyStimulus(P_MEMADR, rb(), rb(), 1'b0);
        waitPhase(P_MEMRD, mw, ok);
        if (ok) applyStimulus(P_MEMWB, rb(), rb(), 1'b0);
        else errorTail(2);
      end
      OP_SW: begin
        applyStimulus(P_MEMADR, rb(), rb(), 1'b0);
        waitPhase(P_MEMWR, mw, ok);
        if (!ok) errorTail(2);
      end
      OP_BEQ:  applyStimulus(P_BRANCH, z, rb(), 1'b0);
      OP_ADDI: begin
        applyStimulus(P_ADDIEX, rb(), rb(), 1'b0);
        applyStimulus(P_ADDIWB, rb(), rb(), 1'b0);
      end
      OP_J:    applyStimulus(P_JUMP, rb(), rb(), 1'b0);
      default: errorTail(10);
    endcase
  endtask

  function automatic int randWaits();
    int r = int'($urandom % 20);
    if (r < 14) return r % 4;
    if (r < 18) return 10 + int'($urandom % 6);
    return TO + 1;
  endfunction

  task automatic checkOutput(input logic [20:0] expWord);
    logic [20:0] got;
    got = {State, Error, IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
           ALUSrcB, ALUControl, RegWrite, RegDst, MemtoReg};
    total++;
    if (got !== expWord) begin
      bad++;
      $display("[TB] FAIL ctrl cyc%0d state%0d: got=%06h want=%06h", cycleNo,
               expWord[20:17], got, expWord);
    end
  endtask

  // Monitor: consumes one expected word per cycle, independent of the stimulus thread.
  always @(negedge CLK) begin
    cycleNo++;
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    bit ok;
    curOpc = OP_R; curFn = 6'h20;
    Opcode = 0; Funct = 0; Zero = 0; MemReady = 0; rst = 1;
    @(posedge CLK); #1;
    applyStimulus(P_FETCH, 1'b0, 1'b1, 1'b1);

    runInstr(OP_R, 6'h20, 1'b0, 0, 0);
    runInstr(OP_LW, 6'h00, 1'b0, 1, 3);
    runInstr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    runInstr(OP_BEQ, 6'h00, 1'b0, 0, 0);
    runInstr(6'h3F, 6'h00, 1'b0, 0, 0);
    runInstr(OP_ADDI, 6'h00, 1'b0, TO + 1, 0);
    runInstr(OP_ADDI, 6'h00, 1'b0, TO, 0);
    runInstr(OP_LW, 6'h00, 1'b0, 0, TO + 1);
    runInstr(OP_SW, 6'h00, 1'b0, 0, TO);
    runInstr(OP_R, 6'h3F, 1'b0, 0, 0);

    curOpc = OP_SW; curFn = 6'h00;
    applyStimulus(P_FETCH, 1'b0, 1'b1, 1'b0);
    applyStimulus(P_DECODE, 1'b0, 1'b0, 1'b0);
    applyStimulus(P_MEMADR, 1'b0, 1'b0, 1'b0);
    waitPhase(P_MEMWR, 0, ok);
    curOpc = OP_SW;
    applyStimulus(P_FETCH, 1'b0, 1'b1, 1'b0);
    applyStimulus(P_DECODE, 1'b0, 1'b0, 1'b0);
    applyStimulus(P_MEMADR, 1'b0, 1'b0, 1'b0);
    applyStimulus(P_MEMWR, 1'b0, 1'b0, 1'b0);
    applyStimulus(P_MEMWR, 1'b0, 1'b0, 1'b1);
    runInstr(OP_J, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] opc;
      logic [5:0] fn;
      int k = int'($urandom % 8);
      fn = legalFn[$urandom % 5];
      case (k)
        0: opc = OP_R;
        1: begin opc = OP_R; fn = 6'($urandom); end
        2: opc = OP_LW;
        3: opc = OP_SW;
        4: opc = OP_BEQ;
        5: opc = OP_ADDI;
        6: opc = OP_J;
        default: opc = 6'($urandom);
      endcase
      runInstr(opc, fn, rb(), randWaits(), randWaits());
    end

    @(negedge CLK); @(negedge CLK);
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got=%0d pending want=0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
